// File: rtl/msg_seq_tx.sv
// Message-send coprocessor: streams a selected parameter-stored message, one byte
// per acknowledged bus write, to the UART TX data register.
module msg_seq_tx #(
    parameter int unsigned NUM_MSG  = 2,
    parameter int unsigned MAX_LEN  = 16,
    parameter logic [NUM_MSG*8-1:0] MSG_LENS = {8'd2, 8'd10},
    parameter logic [NUM_MSG*MAX_LEN*8-1:0] MSG_DATA =
        {112'h0, 16'h0A0D, 48'h0, 80'h35_35_36_30_31_33_33_32_30_32},
    parameter logic [31:0] UART_ADDR = 32'h3000_000C,
    parameter int unsigned SEL_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             abort_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic             err_o,
    output logic [7:0]       sent_cnt_o,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      wdata_o
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NUM_BYT = NUM_MSG * MAX_LEN;
    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [31:0]        waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [7:0]         len_tbl [NUM_MSG];
    logic [7:0]         byte_tbl [NUM_BYT];
    logic [CNT_W-1:0]   raw_len_c;
    logic [CNT_W-1:0]   sel_len_c;
    logic               sel_ok_c;
    logic [7:0]         byte_c;

    // Unpack the flat parameter tables into indexable arrays.
    for (genvar m = 0; m < NUM_MSG; m++) begin : g_len
        assign len_tbl[m] = MSG_LENS[m*8 +: 8];
    end
    for (genvar i = 0; i < NUM_BYT; i++) begin : g_byte
        assign byte_tbl[i] = MSG_DATA[i*8 +: 8];
    end

    // Length of the requested message, clamped to the table depth.
    always_comb begin
        raw_len_c = '0;
        for (int m = 0; m < NUM_MSG; m++) begin
            if (sel_i == SEL_W'(m)) begin
                raw_len_c = len_tbl[m];
            end
        end
        sel_len_c = (raw_len_c > MAX_LEN_C) ? MAX_LEN_C : raw_len_c;
        sel_ok_c  = 32'(sel_i) < NUM_MSG;
    end

    // State register and all flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state plus index/count/error bookkeeping.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sel_d = sel_i;
                    len_d = sel_len_c;
                    idx_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (!sel_ok_c || sel_len_c == '0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (ack_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    idx_d = idx_q + CNT_W'(1);
                end
                if (abort_i) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (ack_i && idx_q == len_q - CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from the upcoming state so they align with it.
    always_comb begin
        byte_c = '0;
        for (int m = 0; m < NUM_MSG; m++) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if (sel_d == SEL_W'(m) && idx_d == CNT_W'(k)) begin
                    byte_c = byte_tbl[m*MAX_LEN + k];
                end
            end
        end
        busy_d  = (state_d == SEND);
        we_d    = (state_d == SEND);
        ready_d = (state_d == DONE);
        waddr_d = we_d ? UART_ADDR : 32'h0;
        wdata_d = we_d ? {24'h0, byte_c} : 32'h0;
    end

    assign busy_o     = busy_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign sent_cnt_o = cnt_q;
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;

endmodule
